// File: rtl/psum_rx_pkg.sv
// Shared defaults and sample type for the partial-sum receive FIFO.
package psum_rx_pkg;

    localparam int PSUM_IN_W  = 21;
    localparam int PSUM_OUT_W = 16;
    localparam int PSUM_DEPTH = 4;

    typedef logic signed [PSUM_OUT_W-1:0] psum_t;

endpackage

// File: rtl/psum_sat.sv
// Write-path narrowing of a signed partial sum from IN_W to OUT_W bits.
// Saturates when PSUM_RX_SAT_EN is defined, otherwise keeps the low OUT_W bits.
module psum_sat
    import psum_rx_pkg::*;
#(
    parameter int IN_W  = PSUM_IN_W,
    parameter int OUT_W = PSUM_OUT_W
)(
    input  logic signed [IN_W-1:0]  in_data,
    output logic signed [OUT_W-1:0] out_data
);

`ifdef PSUM_RX_SAT_EN
    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    logic in_range;

    // In range when every bit from the OUT_W sign position upward matches.
    assign in_range = (in_data[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){1'b0}}) ||
                      (in_data[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){1'b1}});

    always_comb begin
        out_data = in_data[OUT_W-1:0];
        if (!in_range) begin
            out_data = in_data[IN_W-1] ? MIN_V : MAX_V;
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^in_data;
    assign out_data  = in_data[OUT_W-1:0];
`endif

endmodule

// File: rtl/psum_rx_fifo.sv
// Show-ahead receive FIFO for the partial-sum delay path; drops and flags pushes while full.
// Optional build macro: PSUM_RX_SAT_EN (saturate instead of wrap when narrowing).
module psum_rx_fifo
    import psum_rx_pkg::*;
#(
    parameter int IN_W  = PSUM_IN_W,
    parameter int OUT_W = PSUM_OUT_W,
    parameter int DEPTH = PSUM_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic signed [OUT_W-1:0] mem [DEPTH];
    logic signed [OUT_W-1:0] wdata;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    push;
    logic                    pop;
    logic                    drop;

    psum_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .in_data  (in_data),
        .out_data (wdata)
    );

    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule
